// File: rtl/char_plotter.sv
// Glyph plotter: draws an 8x16 character or clears the screen, one pixel per cycle.
// Latency: first pixel 2 cycles after accept, DONE at +130; READY low while busy, new commands wait.
module char_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                REQ_VALID,
    input  logic [6:0]          CHAR,
    input  logic [4:0]          CELL_COL,
    input  logic [3:0]          CELL_ROW,
    input  logic [COLOUR_W-1:0] FG,
    input  logic [COLOUR_W-1:0] BG,
    input  logic                TRANSPARENT,
    input  logic                CLR_REQ,
    output logic                READY,
    output logic [6:0]          CHAR_CODE,
    input  logic [127:0]        GLYPH,
    output logic [X_W-1:0]      X,
    output logic [Y_W-1:0]      Y,
    output logic [COLOUR_W-1:0] COLOUR,
    output logic                PLOT,
    output logic                DONE
);

    typedef enum logic [2:0] {IDLE, LOAD, DRAW, CLEAR, FIN} state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    state_t                state_q, state_d;
    logic [6:0]            char_q, char_d;
    logic [4:0]            col_q, col_d;
    logic [3:0]            row_q, row_d;
    logic [COLOUR_W-1:0]   fg_q, fg_d;
    logic [COLOUR_W-1:0]   bg_q, bg_d;
    logic                  tr_q, tr_d;
    logic [127:0]          glyph_q, glyph_d;
    logic [6:0]            k_q, k_d;
    logic [X_W-1:0]        cx_q, cx_d;
    logic [Y_W-1:0]        cy_q, cy_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic                  plot_q, plot_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;

    logic [2:0]            px;
    logic [3:0]            py;
    logic                  pix_bit;
    logic [7:0]            xf;
    logic [7:0]            yf;

    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        col_d   = col_q;
        row_d   = row_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        tr_d    = tr_q;
        glyph_d = glyph_q;
        k_d     = k_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            IDLE: begin
                if (CLR_REQ || REQ_VALID) begin
                    char_d = CHAR;
                    col_d  = CELL_COL;
                    row_d  = CELL_ROW;
                    fg_d   = FG;
                    bg_d   = BG;
                    tr_d   = TRANSPARENT;
                    if (CLR_REQ) begin
                        state_d = CLEAR;
                        cx_d    = '0;
                        cy_d    = '0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // Registering the glyph keeps the decoder's combinational path out of DRAW.
                glyph_d = GLYPH;
                k_d     = '0;
                state_d = DRAW;
            end
            DRAW: begin
                if (k_q == 7'd127) begin
                    state_d = FIN;
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            CLEAR: begin
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        state_d = FIN;
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so pixel k appears in cycle 2+k.
    always_comb begin
        px       = k_d[2:0];
        py       = k_d[6:3];
        pix_bit  = glyph_d[7'd127 - k_d];
        xf       = {col_d, px};
        yf       = {row_d, py};
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = (state_d == FIN);
        ready_d  = (state_d == IDLE);
        if (state_d == DRAW) begin
            if ((pix_bit || !tr_d) && (32'(xf) < SCREEN_W) && (32'(yf) < SCREEN_H)) begin
                plot_d   = 1'b1;
                x_d      = X_W'(xf);
                y_d      = Y_W'(yf);
                colour_d = pix_bit ? fg_d : bg_d;
            end
        end else if (state_d == CLEAR) begin
            plot_d   = 1'b1;
            x_d      = cx_d;
            y_d      = cy_d;
            colour_d = bg_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            char_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            tr_q     <= 1'b0;
            glyph_q  <= '0;
            k_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            char_q   <= char_d;
            col_q    <= col_d;
            row_q    <= row_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            tr_q     <= tr_d;
            glyph_q  <= glyph_d;
            k_q      <= k_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign READY     = ready_q;
    assign CHAR_CODE = char_q;
    assign X         = x_q;
    assign Y         = y_q;
    assign COLOUR    = colour_q;
    assign PLOT      = plot_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_char_plotter.sv
// Bench for char_plotter: behavioural font/raster model, randomized draws, clear and reset scenarios.
module tb_char_plotter;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         REQ_VALID;
    logic [6:0]   CHAR;
    logic [4:0]   CELL_COL;
    logic [3:0]   CELL_ROW;
    logic [2:0]   FG;
    logic [2:0]   BG;
    logic         TRANSPARENT;
    logic         CLR_REQ;
    logic         READY;
    logic [6:0]   CHAR_CODE;
    logic [127:0] GLYPH;
    logic [7:0]   X;
    logic [6:0]   Y;
    logic [2:0]   COLOUR;
    logic         PLOT;
    logic         DONE;

    int checks   = 0;
    int failures = 0;

    typedef struct {int cyc; int x; int y; int c;} pix_t;
    pix_t exp_q[$];
    pix_t got_q[$];
    int   ndone, done_cyc, ready_bad, code_bad;

    char_plotter dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .CHAR(CHAR),
        .CELL_COL(CELL_COL), .CELL_ROW(CELL_ROW), .FG(FG), .BG(BG),
        .TRANSPARENT(TRANSPARENT), .CLR_REQ(CLR_REQ), .READY(READY),
        .CHAR_CODE(CHAR_CODE), .GLYPH(GLYPH), .X(X), .Y(Y), .COLOUR(COLOUR),
        .PLOT(PLOT), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Stand-in for the glyph decoder: hand-drawn A/I/H, hashed rows otherwise.
    function automatic logic [127:0] font(input logic [6:0] c);
        logic [127:0] g;
        g = '0;
        case (c)
            7'd65: g = {8'h00, 8'h10, 8'h28, 8'h28, 8'h3C, 8'h44, 8'h44, 8'h44, 64'h0};
            7'd73: g = {8'h00, 8'h38, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h38, 56'h0};
            7'd72: g = {8'h00, 8'h42, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h42, 8'h42, 56'h0};
            default: begin
                for (int r = 0; r < 16; r++)
                    g[8*(15-r) +: 8] = 8'(int'(c) * 37 + r * 113) ^ 8'(int'(c) >> (r % 4));
            end
        endcase
        return g;
    endfunction

    assign GLYPH = font(CHAR_CODE);

    task automatic build_expected(input logic [6:0] ch, input int col, input int row,
                                  input int fg, input int bg, input bit tr);
        logic [127:0] g;
        logic [7:0]   line;
        int           x, y;
        g = font(ch);
        exp_q.delete();
        for (int py = 0; py < 16; py++) begin
            line = g[8*(15-py) +: 8];
            for (int px = 0; px < 8; px++) begin
                x = col * 8 + px;
                y = row * 16 + py;
                if ((line[7-px] || !tr) && x < 160 && y < 120)
                    exp_q.push_back('{2 + py * 8 + px, x, y, line[7-px] ? fg : bg});
            end
        end
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (READY !== 1'b1 && t < 300) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (READY !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_timeout: READY=%b required 1", name, READY);
        end
    endtask

    // Called at the negedge of the accept cycle; observes cycles 1..132.
    task automatic collect(input logic [6:0] ch, input bit scramble);
        got_q.delete();
        ndone = 0; done_cyc = -1; ready_bad = 0; code_bad = 0;
        for (int n = 1; n <= 132; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                REQ_VALID = 1'b0;
                CLR_REQ   = 1'b0;
            end
            if (PLOT === 1'b1) got_q.push_back('{n, int'(X), int'(Y), int'(COLOUR)});
            if (DONE === 1'b1) begin ndone++; done_cyc = n; end
            if (READY !== (n >= 131)) ready_bad++;
            if (n <= 130 && CHAR_CODE !== ch) code_bad++;
            if (scramble && n <= 129) begin
                CHAR        = 7'($urandom);
                CELL_COL    = 5'($urandom);
                CELL_ROW    = 4'($urandom);
                FG          = 3'($urandom);
                BG          = 3'($urandom);
                TRANSPARENT = 1'($urandom);
            end
        end
    endtask

    task automatic check_stream(input string name, input int want_count);
        int mism, first;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d plots required %0d", name, got_q.size(), exp_q.size());
        end
        mism = 0; first = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] != exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL %s_pixels: %0d bad, first #%0d got cyc=%0d x=%0d y=%0d c=%0d required cyc=%0d x=%0d y=%0d c=%0d",
                     name, mism, first, got_q[first].cyc, got_q[first].x, got_q[first].y, got_q[first].c,
                     exp_q[first].cyc, exp_q[first].x, exp_q[first].y, exp_q[first].c);
        end
        checks++;
        if (ndone != 1 || done_cyc != 130) begin
            failures++;
            $display("FAIL %s_done: %0d pulses last in cycle %0d required 1 in cycle 130", name, ndone, done_cyc);
        end
        checks++;
        if (ready_bad != 0) begin
            failures++;
            $display("FAIL %s_ready: %0d cycles wrong, required low 1..130 and high from 131", name, ready_bad);
        end
        checks++;
        if (code_bad != 0) begin
            failures++;
            $display("FAIL %s_char_code: %0d cycles differ from latched char", name, code_bad);
        end
        if (want_count >= 0) begin
            checks++;
            if (got_q.size() != want_count) begin
                failures++;
                $display("FAIL %s_plot_total: got %0d required %0d", name, got_q.size(), want_count);
            end
        end
    endtask

    function automatic int got_colour(input int x, input int y);
        foreach (got_q[i]) if (got_q[i].x == x && got_q[i].y == y) return got_q[i].c;
        return -1;
    endfunction

    task automatic start_draw(input logic [6:0] ch, input int col, input int row,
                              input int fg, input int bg, input bit tr, input string name);
        wait_ready(name);
        build_expected(ch, col, row, fg, bg, tr);
        CHAR = ch; CELL_COL = 5'(col); CELL_ROW = 4'(row);
        FG = 3'(fg); BG = 3'(bg); TRANSPARENT = tr; REQ_VALID = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ_VALID = 1'b0; CLR_REQ = 1'b0; CHAR = 7'd0;
        CELL_COL = '0; CELL_ROW = '0; FG = '0; BG = '0; TRANSPARENT = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({READY, PLOT, DONE, X, Y, COLOUR, CHAR_CODE} !== {1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 7'd0}) begin
            failures++;
            $display("FAIL reset_values: READY=%b PLOT=%b DONE=%b X=%0d Y=%0d COLOUR=%0d CHAR_CODE=%0d required 1 0 0 0 0 0 0",
                     READY, PLOT, DONE, X, Y, COLOUR, CHAR_CODE);
        end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_char_a();
        int c;
        start_draw(7'd65, 0, 0, 7, 0, 1'b0, "A");
        collect(7'd65, 1'b0);
        check_stream("A", 128);
        c = got_colour(3, 1); checks++;
        if (c != 7) begin failures++; $display("FAIL A_px_3_1: colour %0d required 7", c); end
        c = got_colour(0, 0); checks++;
        if (c != 0) begin failures++; $display("FAIL A_px_0_0: colour %0d required 0", c); end
        c = got_colour(1, 4); checks++;
        if (c != 0) begin failures++; $display("FAIL A_px_1_4: colour %0d required 0", c); end
        c = got_colour(2, 4); checks++;
        if (c != 7) begin failures++; $display("FAIL A_px_2_4: colour %0d required 7", c); end
    endtask

    task automatic test_transparent_i();
        start_draw(7'd73, 2, 1, 5, 3, 1'b1, "I");
        collect(7'd73, 1'b0);
        check_stream("I", 12);
        checks++;
        if (got_q.size() == 0 || got_q[0].x != 18 || got_q[0].y != 17 || got_q[0].c != 5) begin
            failures++;
            $display("FAIL I_first_plot: %0d plots, first differs from x=18 y=17 c=5", got_q.size());
        end
    endtask

    task automatic test_clip_h();
        start_draw(7'd72, 19, 7, 6, 1, 1'b0, "H");
        collect(7'd72, 1'b0);
        check_stream("H", 64);
    endtask

    task automatic test_clear_priority();
        int bad, plots, nd, dn, rb, lx, ly;
        wait_ready("clr");
        CHAR = 7'd90; CELL_COL = 5'd3; CELL_ROW = 4'd2; FG = 3'd4; BG = 3'd2; TRANSPARENT = 1'b0;
        build_expected(7'd90, 3, 2, 4, 2, 1'b0);
        CLR_REQ = 1'b1; REQ_VALID = 1'b1;
        bad = 0; plots = 0; nd = 0; dn = -1; rb = 0; lx = -1; ly = -1;
        for (int n = 1; n <= 19202; n++) begin
            @(negedge CLK);
            if (n == 1) CLR_REQ = 1'b0;
            if (n <= 19200) begin
                if (PLOT !== 1'b1 || X !== 8'((n - 1) % 160) || Y !== 7'((n - 1) / 160) || COLOUR !== 3'd2) bad++;
            end else if (PLOT === 1'b1) begin
                bad++;
            end
            if (PLOT === 1'b1) begin plots++; lx = int'(X); ly = int'(Y); end
            if (DONE === 1'b1) begin nd++; dn = n; end
            if (READY !== (n >= 19202)) rb++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clr_sweep: %0d bad cycles required 0", bad); end
        checks++;
        if (plots != 19200) begin failures++; $display("FAIL clr_count: %0d plots required 19200", plots); end
        checks++;
        if (lx != 159 || ly != 119) begin failures++; $display("FAIL clr_last: x=%0d y=%0d required 159 119", lx, ly); end
        checks++;
        if (nd != 1 || dn != 19201) begin failures++; $display("FAIL clr_done: %0d pulses at %0d required 1 at 19201", nd, dn); end
        checks++;
        if (rb != 0) begin failures++; $display("FAIL clr_ready: %0d cycles wrong", rb); end
        // REQ_VALID is still high: this IDLE cycle is the accept cycle of the pending draw.
        collect(7'd90, 1'b0);
        check_stream("clr_then_draw", -1);
    endtask

    task automatic test_reset_mid_draw();
        logic [6:0] ch;
        int bad;
        ch = 7'($urandom_range(32, 126));
        start_draw(ch, 0, 0, 6, 1, 1'b0, "rst_mid");
        for (int n = 1; n <= 42; n++) begin
            @(negedge CLK);
            if (n == 1) REQ_VALID = 1'b0;
        end
        checks++;
        if (PLOT !== 1'b1) begin failures++; $display("FAIL rst_mid_k40_plot: PLOT=%b required 1", PLOT); end
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if ({READY, PLOT, DONE, X, Y, COLOUR, CHAR_CODE} !== {1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 7'd0}) begin
            failures++;
            $display("FAIL rst_mid_values: READY=%b PLOT=%b DONE=%b X=%0d Y=%0d COLOUR=%0d CHAR_CODE=%0d required 1 0 0 0 0 0 0",
                     READY, PLOT, DONE, X, Y, COLOUR, CHAR_CODE);
        end
        RESET = 1'b0; bad = 0;
        repeat (150) begin
            @(negedge CLK);
            if (PLOT !== 1'b0 || DONE !== 1'b0 || READY !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_mid_abandon: %0d cycles with activity required 0", bad); end
        ch = 7'($urandom_range(32, 126));
        build_expected(ch, 4, 3, 2, 5, 1'b0);
        CHAR = ch; CELL_COL = 5'd4; CELL_ROW = 4'd3; FG = 3'd2; BG = 3'd5; TRANSPARENT = 1'b0;
        RESET = 1'b1; REQ_VALID = 1'b1; bad = 0;
        repeat (3) begin
            @(negedge CLK);
            if (READY !== 1'b1 || PLOT !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_hold_req: %0d cycles accepted during reset", bad); end
        RESET = 1'b0;
        collect(ch, 1'b0);
        check_stream("post_reset_draw", -1);
    endtask

    task automatic test_char_change();
        logic [6:0] ch;
        ch = 7'($urandom_range(32, 126));
        start_draw(ch, 7, 2, 3, 4, 1'b1, "chg");
        collect(ch, 1'b1);
        check_stream("chg", -1);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ch;
        int col, row, fg, bg;
        bit tr;
        for (int i = 0; i < 8; i++) begin
            ch  = 7'($urandom);
            col = (i == 0) ? 25 : int'($urandom_range(0, 31));
            row = int'($urandom_range(0, 15));
            fg  = int'($urandom_range(0, 7));
            bg  = int'($urandom_range(0, 7));
            tr  = 1'($urandom);
            start_draw(ch, col, row, fg, bg, tr, "b2b");
            collect(ch, 1'b0);
            check_stream("b2b", (i == 0) ? 0 : -1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_char_a();
        test_transparent_i();
        test_clip_h();
        test_clear_priority();
        test_reset_mid_draw();
        test_char_change();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
